// File: rtl/n64_pi_initiator.sv
// -----------------------------------------------------------------------------
// n64_pi_initiator
//
// Host-side (RCP role) driver for the N64 Parallel Interface bus. Each internal
// request becomes one 32-bit transfer on the pins:
//   address phase : ALEH+ALEL high with addr[31:16] on AD, then ALEL only with
//                   addr[15:0]
//   setup         : ALEL low, AD turned around (read) or preloaded (write)
//   two strobes   : READ or WRITE low for T_PULSE cycles, then high for
//                   T_RELEASE cycles; high halfword first, low halfword second
//   done          : one-cycle ack, read word presented on o_data
//
// Optional feature (macro PI_BURST_CONTINUE_EN):
//   Remembers the last completed word address and direction. A request for
//   last+4 in the same direction skips the address phase and setup entirely,
//   relying on the responder's internal address auto-increment.
//
// Parameters (cycles, each 1..15):
//   T_ALE      length of each ALE sub-phase (ALEH-high, then ALEL-only)
//   T_SETUP    ALEL fall to first strobe
//   T_PULSE    strobe low time
//   T_RELEASE  strobe high time after each pulse
//
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_request          start a transfer (sampled only while o_busy=0)
//   i_write            1=write, 0=read (latched with i_request)
//   i_address          byte address; bits [1:0] forced to 0
//   i_data             write data (latched with i_request)
//   o_busy             transfer in progress (low again in the ack cycle)
//   o_ack              one-cycle completion pulse
//   o_data             read data, valid with o_ack, held until next read ack
//   o_pi_aleh/alel     PI address latch enables
//   o_pi_read/write    PI strobes, active low
//   o_pi_ad, o_pi_ad_oe  AD drive value and enable (tristate is in the top)
//   i_pi_ad            AD sampled value
// -----------------------------------------------------------------------------
module n64_pi_initiator #(
  parameter int unsigned T_ALE     = 4,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_PULSE   = 6,
  parameter int unsigned T_RELEASE = 3
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_request,
  input  logic        i_write,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_ack,
  output logic [31:0] o_data,
  output logic        o_pi_aleh,
  output logic        o_pi_alel,
  output logic        o_pi_read,
  output logic        o_pi_write,
  output logic [15:0] o_pi_ad,
  output logic        o_pi_ad_oe,
  input  logic [15:0] i_pi_ad
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALE_H,
    S_ALE_L,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_DONE
  } state_e;

  localparam logic [3:0] LD_ALE     = 4'(T_ALE);
  localparam logic [3:0] LD_SETUP   = 4'(T_SETUP);
  localparam logic [3:0] LD_PULSE   = 4'(T_PULSE);
  localparam logic [3:0] LD_RELEASE = 4'(T_RELEASE);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;       // cycles left in the current phase
  logic        hw_q, hw_d;         // 0: high halfword, 1: low halfword
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;   // read word being assembled
  logic [31:0] odata_q, odata_d;   // read word presented to the user side

  // Word-aligned form of the incoming address; masking (rather than slicing)
  // keeps every input bit in use.
  logic [31:0] req_addr;
  assign req_addr = i_address & 32'hFFFF_FFFC;

  logic phase_last;
  assign phase_last = (cnt_q == 4'd1);

`ifdef PI_BURST_CONTINUE_EN
  logic [31:0] last_addr_q, last_addr_d;
  logic        last_write_q, last_write_d;
  logic        last_valid_q, last_valid_d;
  logic        continue_hit;

  // The responder has already advanced to last+4 after the previous transfer,
  // so the address phase can be skipped when the request lines up with it.
  assign continue_hit = last_valid_q
                     && (req_addr == last_addr_q + 32'd4)
                     && (i_write == last_write_q);
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hw_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hw_q    <= hw_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      odata_q <= odata_d;
    end
  end

`ifdef PI_BURST_CONTINUE_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_addr_q  <= '0;
      last_write_q <= 1'b0;
      last_valid_q <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      last_write_q <= last_write_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hw_d    = hw_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    odata_d = odata_q;
`ifdef PI_BURST_CONTINUE_EN
    last_addr_d  = last_addr_q;
    last_write_d = last_write_q;
    last_valid_d = last_valid_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_request) begin
          write_d = i_write;
          addr_d  = req_addr;
          wdata_d = i_data;
          hw_d    = 1'b0;
`ifdef PI_BURST_CONTINUE_EN
          if (continue_hit) begin
            state_d = S_STROBE;
            cnt_d   = LD_PULSE;
          end else begin
            state_d = S_ALE_H;
            cnt_d   = LD_ALE;
          end
`else
          state_d = S_ALE_H;
          cnt_d   = LD_ALE;
`endif
        end
      end

      S_ALE_H: begin
        if (phase_last) begin
          state_d = S_ALE_L;
          cnt_d   = LD_ALE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ALE_L: begin
        if (phase_last) begin
          state_d = S_SETUP;
          cnt_d   = LD_SETUP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_SETUP: begin
        if (phase_last) begin
          state_d = S_STROBE;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_STROBE: begin
        if (phase_last) begin
          // Sample AD at the end of the pulse, when the responder has had the
          // full strobe time to drive it.
          if (!write_q) begin
            if (hw_q) rdata_d[15:0]  = i_pi_ad;
            else      rdata_d[31:16] = i_pi_ad;
          end
          state_d = S_RELEASE;
          cnt_d   = LD_RELEASE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RELEASE: begin
        if (phase_last) begin
          if (!hw_q) begin
            hw_d    = 1'b1;
            state_d = S_STROBE;
            cnt_d   = LD_PULSE;
          end else begin
            // o_data is loaded on DONE entry so it is already valid in the
            // ack cycle; writes leave the last read word untouched.
            if (!write_q) odata_d = rdata_q;
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        hw_d    = 1'b0;
`ifdef PI_BURST_CONTINUE_EN
        last_addr_d  = addr_q;
        last_write_d = write_q;
        last_valid_d = 1'b1;
`endif
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        hw_d    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the registered state so an asynchronous reset
  // returns the pins to idle values immediately.
  // ---------------------------------------------------------------------------
  logic [15:0] wr_half;
  assign wr_half = hw_q ? wdata_q[15:0] : wdata_q[31:16];

  always_comb begin
    o_pi_aleh  = 1'b0;
    o_pi_alel  = 1'b0;
    o_pi_read  = 1'b1;
    o_pi_write = 1'b1;
    o_pi_ad    = '0;
    o_pi_ad_oe = 1'b0;
    o_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    o_ack      = (state_q == S_DONE);

    unique case (state_q)
      S_ALE_H: begin
        o_pi_aleh  = 1'b1;
        o_pi_alel  = 1'b1;
        o_pi_ad    = addr_q[31:16];
        o_pi_ad_oe = 1'b1;
      end
      S_ALE_L: begin
        o_pi_alel  = 1'b1;
        o_pi_ad    = addr_q[15:0];
        o_pi_ad_oe = 1'b1;
      end
      S_SETUP, S_RELEASE: begin
        // Reads release AD for the responder; writes keep the current
        // halfword stable around each strobe.
        if (write_q) begin
          o_pi_ad    = wr_half;
          o_pi_ad_oe = 1'b1;
        end
      end
      S_STROBE: begin
        if (write_q) begin
          o_pi_write = 1'b0;
          o_pi_ad    = wr_half;
          o_pi_ad_oe = 1'b1;
        end else begin
          o_pi_read  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_data = odata_q;

endmodule

// File: tb/tb_n64_pi_initiator.sv
// -----------------------------------------------------------------------------
// tb_n64_pi_initiator
//
// Bench for n64_pi_initiator. A behavioural cartridge responder latches the
// address from the ALE phase, serves halfwords from a fixed word function and
// auto-increments by 2 after every strobe. Each request pushes its expected
// outcome to a scoreboard; the monitor pops it on o_ack and compares latency,
// bus activity, write halfwords and read data.
// Define PI_BURST_CONTINUE_EN for both files to exercise the continuation path.
// -----------------------------------------------------------------------------
module tb_n64_pi_initiator;

  localparam int T_PULSE   = 6;
  localparam int LAT_FULL  = 32;
  localparam int ALE_FULL  = 8;
`ifdef PI_BURST_CONTINUE_EN
  localparam int LAT_CONT  = 20;
  localparam int ALE_CONT  = 0;
`else
  localparam int LAT_CONT  = 32;
  localparam int ALE_CONT  = 8;
`endif

  logic        i_clk     = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_request = 1'b0;
  logic        i_write   = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_data    = '0;
  logic        o_busy, o_ack;
  logic [31:0] o_data;
  logic        o_pi_aleh, o_pi_alel, o_pi_read, o_pi_write, o_pi_ad_oe;
  logic [15:0] o_pi_ad, i_pi_ad;

  always #5 i_clk = ~i_clk;

  n64_pi_initiator dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_request  (i_request),
    .i_write    (i_write),
    .i_address  (i_address),
    .i_data     (i_data),
    .o_busy     (o_busy),
    .o_ack      (o_ack),
    .o_data     (o_data),
    .o_pi_aleh  (o_pi_aleh),
    .o_pi_alel  (o_pi_alel),
    .o_pi_read  (o_pi_read),
    .o_pi_write (o_pi_write),
    .o_pi_ad    (o_pi_ad),
    .o_pi_ad_oe (o_pi_ad_oe),
    .i_pi_ad    (i_pi_ad)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Cartridge responder
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] cart_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h1000_0000) return 32'h8037_1240;
    return {w[15:0] ^ 16'h3C3C, w[31:16] ^ 16'hA5A5};
  endfunction

  logic [31:0] resp_addr = '0;
  logic [31:0] resp_word;
  assign resp_word = cart_word(resp_addr);
  assign i_pi_ad   = resp_addr[1] ? resp_word[15:0] : resp_word[31:16];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;     // expected word-aligned address on AD
    logic [31:0] data;     // write data, or expected read word
    int          lat;      // request cycle to ack cycle, inclusive
    int          ale;      // expected ALE-active cycles
    int          req_cyc;  // cycle the request was driven; -1 = held after ack
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  // Per-transfer observations, cleared on each ack and on reset.
  int          ale_cyc, rd_low, wr_low, busy_cyc, viol, cur_low;
  logic [15:0] ale_hi, ale_lo, last_wr_ad;
  logic [15:0] wr_half[$];
  int          wr_len[$];
  logic        prev_rd = 1'b1, prev_wr = 1'b1;
  int          acks = 0;
  int          last_ack_cyc = 0;
  int          start;

  task automatic clear_obs();
    ale_cyc = 0; rd_low = 0; wr_low = 0; busy_cyc = 0; viol = 0; cur_low = 0;
    ale_hi = '0; ale_lo = '0; last_wr_ad = '0;
    wr_half.delete();
    wr_len.delete();
  endtask

  initial clear_obs();

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      clear_obs();
      prev_rd = 1'b1;
      prev_wr = 1'b1;
    end else begin
      if (o_pi_aleh) begin
        ale_cyc++;
        ale_hi = o_pi_ad;
        resp_addr[31:16] = o_pi_ad;
        if (!o_pi_alel || !o_pi_ad_oe) viol++;
      end else if (o_pi_alel) begin
        ale_cyc++;
        ale_lo = o_pi_ad;
        resp_addr[15:0] = o_pi_ad;
        if (!o_pi_ad_oe) viol++;
      end
      if (o_busy) busy_cyc++;
      if (!o_pi_read) rd_low++;
      if (!o_pi_write) begin
        wr_low++;
        cur_low++;
        last_wr_ad = o_pi_ad;
        if (!o_pi_ad_oe) viol++;
      end
      if (!o_pi_read && !o_pi_write) viol++;
      if (!o_pi_read && o_pi_ad_oe) viol++;
      if (o_busy && o_ack) viol++;
      if (o_pi_write && !prev_wr) begin
        wr_half.push_back(last_wr_ad);
        wr_len.push_back(cur_low);
        cur_low = 0;
        resp_addr = resp_addr + 32'd2;
      end
      if (o_pi_read && !prev_rd) resp_addr = resp_addr + 32'd2;
      prev_rd = o_pi_read;
      prev_wr = o_pi_write;

      if (o_ack) begin
        acks++;
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          start = (e.req_cyc < 0) ? last_ack_cyc + 1 : e.req_cyc;
          check("latency", cyc - start + 1, e.lat);
          check("busy_cycles", busy_cyc, e.lat - 2);
          check("ale_cycles", ale_cyc, e.ale);
          if (e.ale != 0) begin
            check("ale_hi", {16'h0, ale_hi}, {16'h0, e.addr[31:16]});
            check("ale_lo", {16'h0, ale_lo}, {16'h0, e.addr[15:0]});
          end
          check("protocol_violations", viol, 0);
          if (e.wr) begin
            check("read_low_in_write", rd_low, 0);
            check("write_strobes", wr_half.size(), 2);
            if (wr_half.size() == 2) begin
              check("write_hi", {16'h0, wr_half[0]}, {16'h0, e.data[31:16]});
              check("write_lo", {16'h0, wr_half[1]}, {16'h0, e.data[15:0]});
              check("write_len0", wr_len[0], T_PULSE);
              check("write_len1", wr_len[1], T_PULSE);
            end
          end else begin
            check("write_low_in_read", wr_low, 0);
            check("read_low", rd_low, 2 * T_PULSE);
            check("read_data", o_data, e.data);
          end
        end
        last_ack_cyc = cyc;
        clear_obs();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input int ale, input int req_cyc);
    exp_t n;
    n.wr = wr; n.addr = addr; n.data = data; n.lat = lat; n.ale = ale; n.req_cyc = req_cyc;
    sb.push_back(n);
  endtask

  // Drive a one-cycle request; the expected outcome is pushed unless push=0.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_addr, input logic [31:0] exp_data,
                       input int lat, input int ale, input bit push);
    @(negedge i_clk);
    i_request = 1'b1;
    i_write   = wr;
    i_address = addr;
    i_data    = data;
    if (push) push_exp(wr, exp_addr, exp_data, lat, ale, cyc);
    @(negedge i_clk);
    i_request = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int t;
    t = 0;
    while (acks < n && t < budget) begin
      @(negedge i_clk);
      t++;
    end
    check("ack_arrived", acks >= n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #12;
    check("rst_aleh",  o_pi_aleh,  1'b0);
    check("rst_alel",  o_pi_alel,  1'b0);
    check("rst_read",  o_pi_read,  1'b1);
    check("rst_write", o_pi_write, 1'b1);
    check("rst_ad",    o_pi_ad,    16'h0);
    check("rst_ad_oe", o_pi_ad_oe, 1'b0);
    check("rst_busy",  o_busy,     1'b0);
    check("rst_ack",   o_ack,      1'b0);
    check("rst_data",  o_data,     32'h0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Basic read, write, unaligned address
    issue(1'b0, 32'h1000_0000, 32'h0, 32'h1000_0000, 32'h8037_1240, LAT_FULL, ALE_FULL, 1'b1);
    wait_acks(1, 100);
    issue(1'b1, 32'h1FFC_0004, 32'hDEAD_BEEF, 32'h1FFC_0004, 32'hDEAD_BEEF, LAT_FULL, ALE_FULL, 1'b1);
    wait_acks(2, 100);
    issue(1'b0, 32'h1000_0003, 32'h0, 32'h1000_0000, 32'h8037_1240, LAT_FULL, ALE_FULL, 1'b1);
    wait_acks(3, 100);

    // Request pulsed while busy is dropped
    issue(1'b0, 32'h1000_0100, 32'h0, 32'h1000_0100, cart_word(32'h1000_0100), LAT_FULL, ALE_FULL, 1'b1);
    repeat (8) @(negedge i_clk);
    i_request = 1'b1; i_write = 1'b1; i_address = 32'h1000_0400; i_data = 32'h1234_5678;
    @(negedge i_clk);
    i_request = 1'b0;
    wait_acks(4, 100);
    repeat (80) @(negedge i_clk);
    check("busy_request_ignored", acks, 4);

    // Request held across ack: second transfer follows with one idle cycle
    @(negedge i_clk);
    i_request = 1'b1; i_write = 1'b0; i_address = 32'h1000_0200; i_data = '0;
    push_exp(1'b0, 32'h1000_0200, cart_word(32'h1000_0200), LAT_FULL, ALE_FULL, cyc);
    push_exp(1'b0, 32'h1000_0200, cart_word(32'h1000_0200), LAT_FULL, ALE_FULL, -1);
    wait_acks(5, 100);
    repeat (2) @(negedge i_clk);
    i_request = 1'b0;
    wait_acks(6, 100);

    // Reset during the first strobe abandons the transfer
    issue(1'b0, 32'h1000_0300, 32'h0, 32'h0, 32'h0, LAT_FULL, ALE_FULL, 1'b0);
    for (int t = 0; t < 40 && o_pi_read; t++) @(negedge i_clk);
    check("reached_strobe", o_pi_read, 1'b0);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("midrst_read",  o_pi_read,  1'b1);
    check("midrst_write", o_pi_write, 1'b1);
    check("midrst_ad_oe", o_pi_ad_oe, 1'b0);
    check("midrst_busy",  o_busy,     1'b0);
    check("midrst_alel",  o_pi_alel,  1'b0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (50) @(negedge i_clk);
    check("no_ack_after_reset", acks, 6);

    // Sequential addresses: continuation when enabled, full phase otherwise
    issue(1'b0, 32'h1000_0000, 32'h0, 32'h1000_0000, 32'h8037_1240, LAT_FULL, ALE_FULL, 1'b1);
    wait_acks(7, 100);
    issue(1'b0, 32'h1000_0004, 32'h0, 32'h1000_0004, cart_word(32'h1000_0004), LAT_CONT, ALE_CONT, 1'b1);
    wait_acks(8, 100);
    issue(1'b0, 32'h1000_0010, 32'h0, 32'h1000_0010, cart_word(32'h1000_0010), LAT_FULL, ALE_FULL, 1'b1);
    wait_acks(9, 100);

    repeat (10) @(negedge i_clk);
    check("total_acks", acks, 9);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/n64_pi_initiator.md
Name: n64_pi_initiator

Overview:
- Drives the N64 PI bus as the host (RCP side): address phase on ALEH/ALEL, then READ/WRITE strobes. This is the counterpart of the cartridge-side PI responder.
- Used on the bench/dev build to exercise cartridge logic and flash through the real pin protocol.
- Internal side is a single-word request/busy/ack port. Each request performs one 32-bit transfer as two 16-bit halfword strobes, high half first.

Parameters:
- T_ALE, 4, cycles per ALE sub-phase (ALEH-high phase and ALEL-high phase); range 1..15
- T_SETUP, 4, cycles from ALEL fall to first strobe; range 1..15
- T_PULSE, 6, cycles a READ/WRITE strobe is held low; range 1..15
- T_RELEASE, 3, cycles strobe is held high after each pulse; range 1..15

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_request  in  1  start transfer; sampled only while o_busy=0
- i_write  in  1  1=write, 0=read; latched with i_request
- i_address  in  32  byte address; bits [1:0] ignored, driven as 0
- i_data  in  32  write data; latched with i_request
- o_busy  out  1  transfer in progress
- o_ack  out  1  one-cycle completion pulse
- o_data  out  32  read data; valid while o_ack=1, held until next ack
- o_pi_aleh  out  1  PI ALEH
- o_pi_alel  out  1  PI ALEL
- o_pi_read  out  1  PI READ, active-low strobe
- o_pi_write  out  1  PI WRITE, active-low strobe
- o_pi_ad  out  16  AD drive value
- o_pi_ad_oe  out  1  AD output enable; the tristate lives in the top level
- i_pi_ad  in  16  AD sampled value

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: aleh=0, alel=0, read=1, write=1, ad=0, ad_oe=0, busy=0, ack=0, o_data=0.
  - State goes to IDLE, cycle counter 0, halfword index 0.
  - Reset mid-transfer returns to this state immediately; the transfer is abandoned with no ack.
- Handshake:
  - In IDLE, i_request=1 latches write, {address[31:2],2'b00} and data.
  - o_busy=1 from the next cycle until the ack cycle. busy=0 in the same cycle ack=1.
  - Request held high across ack starts a new transfer the cycle after ack (one idle cycle minimum).
  - Requests while busy are ignored, not queued.
- Down-counter: loaded with the phase parameter on phase entry. The phase lasts exactly that many cycles.
- States and outputs:
  - IDLE: idle outputs.
  - ALE_H: aleh=1, alel=1, ad=addr[31:16], ad_oe=1; T_ALE cycles -> ALE_L.
  - ALE_L: aleh=0, alel=1, ad=addr[15:0]; T_ALE cycles -> SETUP.
  - SETUP: alel=0. For a write, ad = first write halfword, ad_oe=1; for a read, ad_oe=0. T_SETUP cycles -> STROBE.
  - STROBE: read or write low per direction. Write drives data[31:16] for halfword 0, data[15:0] for halfword 1. T_PULSE cycles.
    - Read: i_pi_ad captured on the last STROBE cycle into data[31:16] (halfword 0) or data[15:0] (halfword 1).
    - -> RELEASE.
  - RELEASE: strobe high; write data held on AD. T_RELEASE cycles.
    - Then: if halfword 0 -> index=1, STROBE (write AD switches to the low half on entry).
    - Else -> DONE.
  - DONE: ack=1 for one cycle; read data copied to o_data; ad_oe=0 -> IDLE.
- Mutual exclusion: read and write are never low together. ALEH never rises while ALEL is low within a transfer. ad_oe=0 whenever read=0.
- Latency with defaults:
  - Request to ack = 1 + 2*4 + 4 + 2*(6+3) + 1 = 32 cycles.
  - General form: 2 + 2*T_ALE + T_SETUP + 2*(T_PULSE+T_RELEASE).

Optional Feature:
- Macro: PI_BURST_CONTINUE_EN.
- With it:
  - The block keeps the last completed address and direction plus a valid flag. The valid flag is cleared by reset.
  - A new request with address == last+4, same direction and valid flag set skips ALE_H, ALE_L and SETUP and goes straight to STROBE. This relies on the responder's auto-increment.
  - Default latency for a continued transfer is 20 cycles.
  - ALEL/ALEH stay 0 throughout.
- Without it: every request runs the full address phase.

Test Plan:
- Read 0x10000000; bench responder returns 0x8037, then 0x1240 -> o_ack at cycle 32, o_data=0x80371240; AD seen as 0x1000 then 0x0000 during ALE.
- Write 0x1FFC0004 with data 0xDEADBEEF -> strobes carry 0xDEAD then 0xBEEF; write low 6 cycles each; read stays 1; ack at cycle 32.
- Address 0x10000003 -> bus low half driven 0x0000 (bits [1:0] forced 0).
- Request pulsed while busy -> ignored; exactly one ack. Request held high -> second transfer starts the cycle after ack.
- Reset asserted during the first STROBE -> outputs return to idle values immediately (read=1, ad_oe=0); no ack.
- With PI_BURST_CONTINUE_EN: read 0x10000000, then 0x10000004 -> second transfer has no ALE activity, ack after 20 cycles. A following read of 0x10000010 -> full address phase.
